// File: rtl/branch_predictor_pkg.sv
// Shared branch predictor constants: counter states and statistics addresses.
// Imported by the predictor top and its saturating counter.
package branch_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] BP_STAT_BR_ADDR       = 32'hFFFF_FF04;
    localparam logic [31:0] BP_STAT_MISS_ADDR     = 32'hFFFF_FF08;

    function automatic logic [1:0] bp_alloc_ctr(input logic is_jump);
        return is_jump ? CTR_ST : CTR_WT;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state logic.
// Shared by the BTB update path and the gshare PHT.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST)
                ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT)
                ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters and branch/mispredict statistics.
// Define BP_GSHARE_EN to add a global-history PHT for conditional branches.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES   = 64,
    parameter int TAG_BITS  = 10,
    parameter int HIST_BITS = 6
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [31:0]          lookup_pc,
    output logic                 pred_taken,
    output logic [31:0]          pred_target,
    output logic [HIST_BITS-1:0] pred_hist,
    input  logic                 upd_valid,
    input  logic                 upd_is_branch,
    input  logic                 upd_is_jump,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_pred_taken,
    input  logic [31:0]          upd_pred_target,
    input  logic [HIST_BITS-1:0] upd_hist,
    output logic                 mispredict,
    output logic [31:0]          br_count,
    output logic [31:0]          miss_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TLO = IDX + 2;

    typedef logic [IDX-1:0]      idx_t;
    typedef logic [TAG_BITS-1:0] tag_t;

    logic [ENTRIES-1:0] valid_q;
    tag_t               tag_q [ENTRIES];
    logic [29:0]        tgt_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];

    logic [31:0] br_q;
    logic [31:0] miss_q;

    idx_t l_idx;
    tag_t l_tag;
    logic l_hit;
    logic l_dir;

    idx_t u_idx;
    tag_t u_tag;
    logic u_hit;
    logic u_jump;
    logic u_br;
    logic u_alloc;
    logic u_train;
    logic [1:0] u_ctr_next;

    assign l_idx = lookup_pc[IDX+1:2];
    assign l_tag = lookup_pc[TLO+TAG_BITS-1:TLO];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign u_idx = upd_pc[IDX+1:2];
    assign u_tag = upd_pc[TLO+TAG_BITS-1:TLO];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Jump wins if EX ever flags both kinds at once
    assign u_jump  = upd_valid && upd_is_jump;
    assign u_br    = upd_valid && upd_is_branch && !upd_is_jump;
    assign u_alloc = (u_jump || u_br) && !u_hit && upd_taken;
    assign u_train = (u_jump || u_br) && u_hit;

    sat_counter2 u_btb_ctr (
        .ctr      (ctr_q[u_idx]),
        .taken    (upd_taken),
        .ctr_next (u_ctr_next)
    );

`ifdef BP_GSHARE_EN
    logic [ENTRIES-1:0]   jmp_q;
    logic [1:0]           pht_q [ENTRIES];
    logic [HIST_BITS-1:0] ghr_q;
    logic [HIST_BITS-1:0] ghr_shift;
    logic [HIST_BITS-1:0] ghr_fix;
    idx_t                 l_pidx;
    idx_t                 u_pidx;
    logic [1:0]           pht_next;

    assign l_pidx = l_idx ^ idx_t'(ghr_q);
    assign u_pidx = u_idx ^ idx_t'(upd_hist);
    assign l_dir  = jmp_q[l_idx] ? ctr_q[l_idx][1]
                                 : pht_q[l_pidx][1];
    assign pred_hist = ghr_q;

    generate
        if (HIST_BITS == 1) begin : g_h1
            assign ghr_shift = upd_taken;
            assign ghr_fix   = upd_taken;
        end else begin : g_hn
            assign ghr_shift = {ghr_q[HIST_BITS-2:0], upd_taken};
            assign ghr_fix   = {upd_hist[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    sat_counter2 u_pht_ctr (
        .ctr      (pht_q[u_pidx]),
        .taken    (upd_taken),
        .ctr_next (pht_next)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < ENTRIES; i++)
                pht_q[i] <= CTR_WNT;
        end else if (upd_valid && upd_is_branch) begin
            pht_q[u_pidx] <= pht_next;
        end
    end

    // A mispredict repairs history from the snapshot taken at lookup
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            ghr_q <= '0;
        else if (mispredict)
            ghr_q <= ghr_fix;
        else if (upd_valid && upd_is_branch)
            ghr_q <= ghr_shift;
    end

    always_ff @(posedge clk) begin
        if (u_alloc || u_train)
            jmp_q[u_idx] <= u_jump;
    end
`else
    assign l_dir     = ctr_q[l_idx][1];
    assign pred_hist = '0;
`endif

    assign pred_taken  = l_hit && l_dir;
    assign pred_target = pred_taken ? {tgt_q[l_idx], 2'b00}
                                    : lookup_pc + 32'd4;

    assign mispredict = upd_valid &&
        ((upd_taken != upd_pred_taken) ||
         (upd_taken && (upd_target != upd_pred_target)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            valid_q <= '0;
        else if (u_alloc)
            valid_q[u_idx] <= 1'b1;
    end

    // Payload arrays are gated by valid_q, so they carry no reset
    always_ff @(posedge clk) begin
        if (u_alloc) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= upd_target[31:2];
            ctr_q[u_idx] <= bp_alloc_ctr(u_jump);
        end else if (u_train) begin
            if (u_jump || upd_taken)
                tgt_q[u_idx] <= upd_target[31:2];
            ctr_q[u_idx] <= u_jump ? CTR_ST : u_ctr_next;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            br_q   <= '0;
            miss_q <= '0;
        end else begin
            br_q   <= br_q + {31'd0, upd_valid};
            miss_q <= miss_q + {31'd0, mispredict};
        end
    end

    assign br_count   = br_q;
    assign miss_count = miss_q;

    logic unused_bits;
    assign unused_bits = ^{upd_pc, upd_target[1:0], upd_hist};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed steps plus random
// traffic checked against a table-level reference model.
module tb_branch_predictor;

    localparam int ENTRIES   = 64;
    localparam int TAG_BITS  = 10;
    localparam int HIST_BITS = 6;
    localparam int IDX       = $clog2(ENTRIES);

    logic                 clk = 1'b0;
    logic                 nrst = 1'b0;
    logic [31:0]          lookup_pc = 32'h0;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [HIST_BITS-1:0] pred_hist;
    logic                 upd_valid = 1'b0;
    logic                 upd_is_branch = 1'b0;
    logic                 upd_is_jump = 1'b0;
    logic [31:0]          upd_pc = 32'h0;
    logic                 upd_taken = 1'b0;
    logic [31:0]          upd_target = 32'h0;
    logic                 upd_pred_taken = 1'b0;
    logic [31:0]          upd_pred_target = 32'h0;
    logic [HIST_BITS-1:0] upd_hist = '0;
    logic                 mispredict;
    logic [31:0]          br_count;
    logic [31:0]          miss_count;

    branch_predictor #(
        .ENTRIES   (ENTRIES),
        .TAG_BITS  (TAG_BITS),
        .HIST_BITS (HIST_BITS)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .pred_hist       (pred_hist),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_is_jump     (upd_is_jump),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .upd_hist        (upd_hist),
        .mispredict      (mispredict),
        .br_count        (br_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          mv   [ENTRIES];
    int unsigned mtag [ENTRIES];
    logic [31:0] mtgt [ENTRIES];
    int          mctr [ENTRIES];
    logic [31:0] mbr;
    logic [31:0] mmiss;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tag(input logic [31:0] pc);
        return (pc >> (IDX + 2)) % (1 << TAG_BITS);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[m_idx(pc)] && (mtag[m_idx(pc)] == m_tag(pc));
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) mv[i] = 1'b0;
        mbr = 0;
        mmiss = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc,
                                     output logic t,
                                     output logic [31:0] tg);
        t  = m_hit(pc) && (mctr[m_idx(pc)] >= 2);
        tg = t ? mtgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic logic m_misp();
        if (!upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    function automatic void m_update();
        int  i;
        bit  h;
        if (!upd_valid) return;
        mbr = mbr + 1;
        if (m_misp()) mmiss = mmiss + 1;
        i = m_idx(upd_pc);
        h = m_hit(upd_pc);
        if (upd_is_jump || upd_is_branch) begin
            if (h) begin
                if (upd_is_jump) mctr[i] = 3;
                else if (upd_taken) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
                else mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
                if (upd_is_jump || upd_taken) mtgt[i] = upd_target & ~32'd3;
            end else if (upd_taken) begin
                mv[i]   = 1'b1;
                mtag[i] = m_tag(upd_pc);
                mtgt[i] = upd_target & ~32'd3;
                mctr[i] = upd_is_jump ? 3 : 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (nrst) m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic br, input logic jp,
                       input logic [31:0] pc, input logic tk,
                       input logic [31:0] tg, input logic ptk,
                       input logic [31:0] ptg);
        upd_valid       = v;
        upd_is_branch   = br;
        upd_is_jump     = jp;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
        upd_hist        = '0;
    endtask

    task automatic idle();
        upd(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic et, input logic [31:0] etg);
        lookup_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, et});
        chk({tag, "_target"}, pred_target, etg);
    endtask

    task automatic mupd(input logic br, input logic jp,
                        input logic [31:0] pc, input logic tk,
                        input logic [31:0] tg);
        logic        pt;
        logic [31:0] ptg;
        m_lookup(pc, pt, ptg);
        upd(1'b1, br, jp, pc, tk, tg, pt, ptg);
        tick();
        idle();
    endtask

    initial begin : main
        logic        et;
        logic [31:0] etg;
        logic [31:0] rpc;
        logic [31:0] rtg;
        logic        rtk;
        logic        pt;
        logic [31:0] ptg;
        int          kind;

        m_reset();
        idle();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;

        look("rst", 32'h8000, 1'b0, 32'h8004);
        chk("rst_br", br_count, 32'h0);
        chk("rst_miss", miss_count, 32'h0);
        chk("rst_hist", {26'd0, pred_hist}, 32'h0);
        chk("rst_misp", {31'd0, mispredict}, 32'h0);

`ifndef BP_GSHARE_EN
        upd(1'b1, 1'b1, 1'b0, 32'h8010, 1'b1, 32'h8040, 1'b0, 32'h8014);
        look("alloc_same", 32'h8010, 1'b0, 32'h8014);
        chk("alloc_misp", {31'd0, mispredict}, 32'h1);
        tick();
        idle();
        chk("alloc_br", br_count, 32'h1);
        chk("alloc_miss", miss_count, 32'h1);
        look("alloc_hit", 32'h8010, 1'b1, 32'h8040);

        mupd(1'b1, 1'b0, 32'h8010, 1'b0, 32'h8040);
        look("nt1", 32'h8010, 1'b0, 32'h8014);
        mupd(1'b1, 1'b0, 32'h8010, 1'b0, 32'h8040);
        mupd(1'b1, 1'b0, 32'h8010, 1'b1, 32'h8040);
        look("keep_valid", 32'h8010, 1'b0, 32'h8014);
        mupd(1'b1, 1'b0, 32'h8010, 1'b1, 32'h8040);
        look("t2", 32'h8010, 1'b1, 32'h8040);
        mupd(1'b1, 1'b0, 32'h8010, 1'b1, 32'h8040);
        mupd(1'b1, 1'b0, 32'h8010, 1'b1, 32'h8040);
        mupd(1'b1, 1'b0, 32'h8010, 1'b0, 32'h8040);
        look("sat_hi", 32'h8010, 1'b1, 32'h8040);
`endif

        mupd(1'b0, 1'b1, 32'h8010, 1'b1, 32'h8800);
        look("jal_a", 32'h8010, 1'b1, 32'h8800);
        mupd(1'b0, 1'b1, 32'h8110, 1'b1, 32'h9000);
        look("evict_a", 32'h8010, 1'b0, 32'h8014);
        look("evict_b", 32'h8110, 1'b1, 32'h9000);

        upd(1'b1, 1'b0, 1'b1, 32'h8020, 1'b1, 32'h8100, 1'b0, 32'h8024);
        look("same_cyc", 32'h8020, 1'b0, 32'h8024);
        tick();
        idle();
        look("next_cyc", 32'h8020, 1'b1, 32'h8100);

        mupd(1'b0, 1'b0, 32'h8030, 1'b1, 32'h8700);
        look("ctr_only", 32'h8030, 1'b0, 32'h8034);
        chk("ctr_only_br", br_count, mbr);

        for (int it = 0; it < 400; it++) begin
            lookup_pc = 32'h8000 + ($urandom_range(0, 511) << 2);
            rpc = 32'h8000 + ($urandom_range(0, 511) << 2);
            rtg = 32'h8000 + ($urandom_range(0, 511) << 2);
            kind = $urandom_range(0, 9);
`ifdef BP_GSHARE_EN
            if (kind < 6) kind = 6;
`endif
            rtk = (kind >= 6 && kind <= 8) ? 1'b1 : 1'(($urandom_range(0, 1)));
            m_lookup(rpc, pt, ptg);
            if ($urandom_range(0, 3) == 0) pt = ~pt;
            if ($urandom_range(0, 3) == 0) ptg = rtg;
            upd(1'($urandom_range(0, 4) != 0), kind < 6,
                kind >= 6 && kind <= 8, rpc, rtk, rtg, pt, ptg);
            #1;
            m_lookup(lookup_pc, et, etg);
            chk("rnd_taken", {31'd0, pred_taken}, {31'd0, et});
            chk("rnd_target", pred_target, etg);
            chk("rnd_misp", {31'd0, mispredict}, {31'd0, m_misp()});
`ifndef BP_GSHARE_EN
            chk("rnd_hist", {26'd0, pred_hist}, 32'h0);
`endif
            tick();
            chk("rnd_br", br_count, mbr);
            chk("rnd_miss", miss_count, mmiss);
        end
        idle();

        mupd(1'b0, 1'b1, 32'h8040, 1'b1, 32'h8500);
        upd(1'b1, 1'b0, 1'b1, 32'h8050, 1'b1, 32'h8600, 1'b0, 32'h8054);
        nrst = 1'b0;
        m_reset();
        look("mid_rst", 32'h8040, 1'b0, 32'h8044);
        chk("mid_rst_br", br_count, 32'h0);
        chk("mid_rst_miss", miss_count, 32'h0);
        tick();
        nrst = 1'b1;
        idle();
        look("rst_discard", 32'h8050, 1'b0, 32'h8054);
        chk("rst_discard_br", br_count, 32'h0);

        force dut.br_q = 32'hFFFF_FFFF;
        force dut.miss_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_q;
        release dut.miss_q;
        mbr = 32'hFFFF_FFFF;
        mmiss = 32'hFFFF_FFFF;
        upd(1'b1, 1'b0, 1'b1, 32'h8060, 1'b1, 32'h8400, 1'b0, 32'h8064);
        tick();
        idle();
        chk("wrap_br", br_count, 32'h0);
        chk("wrap_miss", miss_count, 32'h0);

`ifdef BP_GSHARE_EN
        for (int it = 0; it < 4 * (HIST_BITS + 2); it++) begin
            logic [HIST_BITS-1:0] ch;
            lookup_pc = 32'h8200;
            #1;
            pt  = pred_taken;
            ptg = pred_target;
            ch  = pred_hist;
            tick();
            upd(1'b1, 1'b1, 1'b0, 32'h8200, 1'((it % 2) == 0),
                32'h8300, pt, ptg);
            upd_hist = ch;
            #1;
            if (it >= 3 * (HIST_BITS + 2))
                chk("gs_misp", {31'd0, mispredict}, 32'h0);
            tick();
            idle();
        end
        chk("gs_br", br_count, mbr);
        chk("gs_miss", miss_count, mmiss);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
